// File: rtl/instr_decode.sv
// RV32I decode stage: single-entry IF/ID register with valid/ready, stall and flush.
// Optional ID_PERF_CNT_EN adds decode_cnt, a wrapping count of non-flushed transfers.
module instr_decode #(
    parameter int unsigned XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instrCode,
    input  logic [XLEN-1:0] pc_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [31:0]     imm,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]     decode_cnt,
`endif
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic            out_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [31:0]     imm_q, imm_d;
    logic [2:0]      fmt_q, fmt_d;
    logic            illegal_q, illegal_d;
    logic            xfer;

    logic [31:0] i;
    assign i = instrCode;

    // Combinational decode of the incoming word; registered only on transfer.
    always_comb begin
        rd_d      = 5'd0;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        imm_d     = 32'd0;
        fmt_d     = FMT_ILL;
        illegal_d = 1'b1;
        case (i[6:0])
            OP_R: begin
                fmt_d = FMT_R; illegal_d = 1'b0;
                rd_d = i[11:7]; rs1_d = i[19:15]; rs2_d = i[24:20];
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_d = FMT_I; illegal_d = 1'b0;
                rd_d = i[11:7]; rs1_d = i[19:15];
                imm_d = {{20{i[31]}}, i[31:20]};
            end
            OP_STORE: begin
                fmt_d = FMT_S; illegal_d = 1'b0;
                rs1_d = i[19:15]; rs2_d = i[24:20];
                imm_d = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            OP_BRANCH: begin
                fmt_d = FMT_B; illegal_d = 1'b0;
                rs1_d = i[19:15]; rs2_d = i[24:20];
                imm_d = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_d = FMT_U; illegal_d = 1'b0;
                rd_d = i[11:7];
                imm_d = {i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_d = FMT_J; illegal_d = 1'b0;
                rd_d = i[11:7];
                imm_d = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: ;
        endcase
        // All-zero / all-one words are explicitly illegal whatever the opcode map says.
        if (i == 32'h0000_0000 || i == 32'hFFFF_FFFF) begin
            rd_d = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
            imm_d = 32'd0; fmt_d = FMT_ILL; illegal_d = 1'b1;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= RST_PC[XLEN-1:0];
            instr_q     <= 32'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            imm_q       <= 32'd0;
            fmt_q       <= FMT_R;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            pc_q        <= pc_in;
            instr_q     <= instrCode;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
        end else if (out_ready && out_valid_q) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else if (xfer && !flush) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
    assign decode_cnt = cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed scenarios plus randomized traffic against a reference model.
module tb_instr_decode;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instrCode = 32'd0;
    logic [31:0] pc_in = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc_out, instr_out, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, fmt;
    logic        illegal;
`ifdef ID_PERF_CNT_EN
    logic [31:0] decode_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    instr_decode dut (
        .clk(clk), .rst(rst), .instrCode(instrCode), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .instr_out(instr_out), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
`ifdef ID_PERF_CNT_EN
        .decode_cnt(decode_cnt),
`endif
        .fmt(fmt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference decode from the ISA rules, immediates built with arithmetic shifts and weights.
    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        int f;
        logic [31:0] sgn;
        case (w[6:0])
            7'h33:               f = 0;
            7'h13, 7'h03, 7'h67: f = 1;
            7'h23:               f = 2;
            7'h63:               f = 3;
            7'h37, 7'h17:        f = 4;
            7'h6F:               f = 5;
            default:             f = 7;
        endcase
        if (w == 32'h0 || w == 32'hFFFF_FFFF) f = 7;
        sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
        d.op  = w[6:0];
        d.f3  = w[14:12];
        d.f7  = w[31:25];
        d.fmt = 3'(f);
        d.ill = (f == 7);
        d.rd  = (f == 0 || f == 1 || f == 4 || f == 5) ? w[11:7] : 5'd0;
        d.rs1 = (f <= 3) ? w[19:15] : 5'd0;
        d.rs2 = (f == 0 || f == 2 || f == 3) ? w[24:20] : 5'd0;
        case (f)
            1: d.imm = 32'($signed(w) >>> 20);
            2: d.imm = 32'($signed(w) >>> 25) * 32'd32 + 32'(w[11:7]);
            3: d.imm = sgn * 32'd4096 + 32'(w[7]) * 32'd2048 + 32'(w[30:25]) * 32'd32
                       + 32'(w[11:8]) * 32'd2;
            4: d.imm = w & 32'hFFFF_F000;
            5: d.imm = sgn * 32'h0010_0000 + 32'(w[19:12]) * 32'd4096
                       + 32'(w[20]) * 32'd2048 + 32'(w[30:21]) * 32'd2;
            default: d.imm = 32'd0;
        endcase
        return d;
    endfunction

    function automatic dec_t got_dec();
        return {opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [6:0] ops [9];
        int sel;
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        sel = int'($urandom_range(0, 15));
        w = $urandom;
        if (sel == 14) w = 32'h0;
        else if (sel == 15) w = 32'hFFFF_FFFF;
        else if (sel < 9) w[6:0] = ops[sel];
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, pc_out, instr_out} !== {1'b0, 32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_regs: valid=%0b pc=%h instr=%h required 0/0/0", out_valid, pc_out, instr_out);
        end
        tests_run++;
        if (got_dec() !== dec_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h required 0", got_dec());
        end
`ifdef ID_PERF_CNT_EN
        tests_run++;
        if (decode_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d required 0", decode_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        in_valid = 1'b1; instrCode = 32'h0050_0093; pc_in = 32'h0; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, fmt, rd, rs1, imm, pc_out} !== {1'b1, 3'd1, 5'd1, 5'd0, 32'h5, 32'h0}) begin
            tests_failed++;
            $display("FAIL addi: valid=%0b fmt=%0d rd=%0d rs1=%0d imm=%h pc=%h required 1/1/1/0/5/0",
                     out_valid, fmt, rd, rs1, imm, pc_out);
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_consume: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_store();
        in_valid = 1'b1; instrCode = 32'h0020_A423; pc_in = 32'h4; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if ({fmt, rd, rs1, rs2, funct3, imm} !== {3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'h8}) begin
            tests_failed++;
            $display("FAIL sw: fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h required 2/0/1/2/2/8",
                     fmt, rd, rs1, rs2, funct3, imm);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; instrCode = 32'h1234_52B7; pc_in = 32'h10;
        cyc();
        instrCode = 32'hFF9F_F06F; pc_in = 32'h14;
        tests_run++;
        if ({out_valid, fmt, rd, imm} !== {1'b1, 3'd4, 5'd5, 32'h1234_5000}) begin
            tests_failed++;
            $display("FAIL b2b_lui: valid=%0b fmt=%0d rd=%0d imm=%h required 1/4/5/12345000",
                     out_valid, fmt, rd, imm);
        end
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, fmt, imm, pc_out} !== {1'b1, 3'd5, 32'hFFFF_FFF8, 32'h14}) begin
            tests_failed++;
            $display("FAIL b2b_jal: valid=%0b fmt=%0d imm=%h pc=%h required 1/5/fffffff8/14",
                     out_valid, fmt, imm, pc_out);
        end
        cyc();
    endtask

    task automatic test_stall();
        dec_t held;
        in_valid = 1'b1; instrCode = 32'h0050_0093; pc_in = 32'h100; out_ready = 1'b0;
        cyc();
        held = got_dec();
        instrCode = 32'h0020_A423; pc_in = 32'h104;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_in_ready[%0d]: got %0b required 0", k, in_ready);
            end
            cyc();
            tests_run++;
            if ({out_valid, pc_out, instr_out, got_dec()} !== {1'b1, 32'h100, 32'h0050_0093, held}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: valid=%0b pc=%h instr=%h required 1/100/00500093",
                         k, out_valid, pc_out, instr_out);
            end
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, pc_out, instr_out, fmt} !== {1'b1, 32'h104, 32'h0020_A423, 3'd2}) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%0b pc=%h instr=%h required 1/104/0020a423",
                     out_valid, pc_out, instr_out);
        end
        cyc();
    endtask

    task automatic test_flush_illegal();
        in_valid = 1'b1; instrCode = 32'h0050_0093; pc_in = 32'h200; out_ready = 1'b0;
        cyc();
        flush = 1'b1; out_ready = 1'b1; instrCode = 32'h1234_52B7;
        cyc();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush: out_valid=%0b required 0", out_valid);
        end
        instrCode = 32'h0000_0000;
        cyc();
        tests_run++;
        if ({out_valid, illegal, fmt, imm} !== {1'b1, 1'b1, 3'd7, 32'h0}) begin
            tests_failed++;
            $display("FAIL illegal_zero: valid=%0b ill=%0b fmt=%0d imm=%h required 1/1/7/0",
                     out_valid, illegal, fmt, imm);
        end
        instrCode = 32'hFFFF_FFFF;
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, illegal, fmt, imm, rd} !== {1'b1, 1'b1, 3'd7, 32'h0, 5'd0}) begin
            tests_failed++;
            $display("FAIL illegal_ones: valid=%0b ill=%0b fmt=%0d imm=%h rd=%0d required 1/1/7/0/0",
                     out_valid, illegal, fmt, imm, rd);
        end
        cyc();
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1'b1; instrCode = 32'h0050_0093; pc_in = 32'h300; out_ready = 1'b0;
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, pc_out} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_mid_stall: valid=%0b pc=%h required 0/0", out_valid, pc_out);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release_valid: got %0b required 0", out_valid);
        end
`ifdef ID_PERF_CNT_EN
        tests_run++;
        if (decode_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL cnt_after_rst: got %0d required 0", decode_cnt);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        tests_run++;
        if (decode_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL cnt_two: got %0d required 2", decode_cnt);
        end
        cyc();
`endif
    endtask

    task automatic test_random();
        bit          m_valid = 1'b0;
        logic [31:0] m_pc = 32'h0, m_instr = 32'h0;
        dec_t        m_dec = '0;
        logic [31:0] m_cnt = 32'h0;
        bit          exp_rdy;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instrCode = rand_word();
            pc_in     = $urandom & 32'hFFFF_FFFC;
            #1;
            exp_rdy = !m_valid || out_ready;
            tests_run++;
            if (in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rnd_in_ready[%0d]: got %0b required %0b", n, in_ready, exp_rdy);
            end
            tests_run++;
            if (out_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL rnd_valid[%0d]: got %0b required %0b", n, out_valid, m_valid);
            end else if (m_valid) begin
                tests_run++;
                if ({pc_out, instr_out, got_dec()} !== {m_pc, m_instr, m_dec}) begin
                    tests_failed++;
                    $display("FAIL rnd_bundle[%0d]: pc=%h instr=%h dec=%h required %h/%h/%h",
                             n, pc_out, instr_out, got_dec(), m_pc, m_instr, m_dec);
                end
            end
`ifdef ID_PERF_CNT_EN
            tests_run++;
            if (decode_cnt !== m_cnt) begin
                tests_failed++;
                $display("FAIL rnd_cnt[%0d]: got %0d required %0d", n, decode_cnt, m_cnt);
            end
`endif
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && exp_rdy) begin
                m_valid = 1'b1; m_pc = pc_in; m_instr = instrCode; m_dec = ref_dec(instrCode);
                m_cnt = m_cnt + 32'd1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_back_to_back();
        test_stall();
        test_flush_illegal();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
